// File: rtl/divisor_arbiter.sv
// divisor_arbiter
//   Shares one iterative divider among N_REQ requesters. Grants are round-robin,
//   only one operation is in flight at a time, and the divider gets a one-cycle
//   start pulse. Each result comes back on a shared response channel, tagged with
//   the id of the requester that owns it.
//
//   Optional feature macro: DIV_ZERO_FAST_EN. When it is defined, a zero
//   denominator skips the divider and answers coc='1, res=num, dz=1 on the cycle
//   after accept. When it is undefined, den==0 goes to the divider like any other
//   operand and rsp_dz is tied 0.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            per-requester handshake (ready is one-hot or zero)
//   req_num/req_den                packed operands, requester i at [i*SIZE +: SIZE]
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_coc/rsp_res/rsp_dz  response payload
//   div_start/div_num/div_den      divider launch side
//   div_coc/div_res/div_done       divider result side
//
// States
//   S_IDLE   | waiting for a request; req_ready driven to the round-robin winner
//   S_LAUNCH | one-cycle div_start pulse
//   S_WAIT   | waiting for div_done
//   S_RESP   | response held until rsp_ready
module divisor_arbiter #(
    parameter int SIZE  = 32,
    parameter int N_REQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*SIZE-1:0]   req_num,
    input  logic [N_REQ*SIZE-1:0]   req_den,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [SIZE-1:0]         rsp_coc,
    output logic [SIZE-1:0]         rsp_res,
    output logic                    rsp_dz,
    output logic                    div_start,
    output logic [SIZE-1:0]         div_num,
    output logic [SIZE-1:0]         div_den,
    input  logic [SIZE-1:0]         div_coc,
    input  logic [SIZE-1:0]         div_res,
    input  logic                    div_done
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   op_id;
    logic [SIZE-1:0]   op_num, op_den;
    logic [SIZE-1:0]   res_coc, res_res;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    int                scan_idx;
    logic [SIZE-1:0]   sel_num, sel_den;
    logic              accept;

    // The scan starts at rr_ptr and wraps, so the first valid requester after
    // the previous owner wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(scan_idx);
            end
        end
    end

    assign sel_num = req_num[int'(grant_id)*SIZE +: SIZE];
    assign sel_den = req_den[int'(grant_id)*SIZE +: SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_nxt           = S_LAUNCH;
`ifdef DIV_ZERO_FAST_EN
                    if (sel_den == '0) state_nxt = S_RESP;
`endif
                end
            end
            S_LAUNCH: state_nxt = S_WAIT;
            // div_done is only looked at here, so a stale done seen during
            // S_LAUNCH cannot complete the operation early.
            S_WAIT:   if (div_done) state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

`ifdef DIV_ZERO_FAST_EN
    logic res_dz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_dz <= 1'b0;
        end else if (state == S_IDLE && accept) begin
            res_dz <= (sel_den == '0);
        end
    end

    assign rsp_dz = res_dz;
`else
    assign rsp_dz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            op_id   <= '0;
            op_num  <= '0;
            op_den  <= '0;
            res_coc <= '0;
            res_res <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                op_num <= sel_num;
                op_den <= sel_den;
                op_id  <= grant_id;
`ifdef DIV_ZERO_FAST_EN
                if (sel_den == '0) begin
                    res_coc <= '1;
                    res_res <= sel_num;
                end
`endif
            end
            if (state == S_WAIT && div_done) begin
                res_coc <= div_coc;
                res_res <= div_res;
            end
            if (state == S_RESP && rsp_ready) begin
                rr_ptr <= (op_id == ID_W'(N_REQ - 1)) ? '0 : op_id + 1'b1;
            end
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = op_id;
    assign rsp_coc   = res_coc;
    assign rsp_res   = res_res;
    assign div_start = (state == S_LAUNCH);
    assign div_num   = op_num;
    assign div_den   = op_den;

endmodule

// File: tb/tb_divisor_arbiter.sv
module tb_divisor_arbiter;
    localparam int SIZE  = 32;
    localparam int N_REQ = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*SIZE-1:0] req_num;
    logic [N_REQ*SIZE-1:0] req_den;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [SIZE-1:0]       rsp_coc;
    logic [SIZE-1:0]       rsp_res;
    logic                  rsp_dz;
    logic                  div_start;
    logic [SIZE-1:0]       div_num;
    logic [SIZE-1:0]       div_den;
    logic [SIZE-1:0]       div_coc;
    logic [SIZE-1:0]       div_res;
    logic                  div_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divisor_arbiter #(.SIZE(SIZE), .N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_num   (req_num),
        .req_den   (req_den),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_coc   (rsp_coc),
        .rsp_res   (rsp_res),
        .rsp_dz    (rsp_dz),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_coc   (div_coc),
        .div_res   (div_res),
        .div_done  (div_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] n, input logic [31:0] d);
        req_num[id*SIZE +: SIZE] = n;
        req_den[id*SIZE +: SIZE] = d;
    endtask

    // Full transaction for requester id, whose req_valid is already high.
    // coc/res are the values the divider stand-in returns.
    task automatic run_op(input int id, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] coc, input logic [31:0] res,
                          input int bp, input bit stale, input bit drop);
        logic [3:0] exp_ready;
        int         guard;
        exp_ready = 4'b0001 << id;
        #1;
        guard = 0;
        while (req_ready == 4'b0000 && guard < 20) begin
            step();
            guard++;
        end
        chk("grant", 32'(req_ready), 32'(exp_ready));
        step();
        if (drop) req_valid[id] = 1'b0;
        if (stale) begin
            div_done = 1'b1;
            div_coc  = 32'hDEAD_BEEF;
            div_res  = 32'hBAD0_0BAD;
        end
        chk("launch_start", 32'(div_start), 32'd1);
        chk("launch_num", div_num, n);
        chk("launch_den", div_den, d);
        chk("launch_no_ready", 32'(req_ready), 32'd0);
        step();
        div_done = 1'b0;
        chk("wait_start_low", 32'(div_start), 32'd0);
        chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        chk("wait2_no_rsp", 32'(rsp_valid), 32'd0);
        div_done = 1'b1;
        div_coc  = coc;
        div_res  = res;
        step();
        div_done = 1'b0;
        div_coc  = 32'h0;
        div_res  = 32'h0;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_coc", rsp_coc, coc);
        chk("rsp_res", rsp_res, res);
        chk("rsp_dz", 32'(rsp_dz), 32'd0);
        for (int i = 0; i < bp; i++) begin
            step();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_coc", rsp_coc, coc);
            chk("bp_res", rsp_res, res);
            chk("bp_id", 32'(rsp_id), 32'(id));
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            chk("bp_no_start", 32'(div_start), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_num   = '0;
        req_den   = '0;
        rsp_ready = 1'b0;
        div_coc   = '0;
        div_res   = '0;
        div_done  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_coc", rsp_coc, 32'd0);
        chk("rst_divnum", div_num, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // All four held high: grant order 0,1,2,3,0.
        set_op(0, 32'd100, 32'd7);
        set_op(1, 32'd50,  32'd8);
        set_op(2, 32'd81,  32'd9);
        set_op(3, 32'd17,  32'd5);
        req_valid = 4'b1111;
        run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0);
        run_op(1, 32'd50,  32'd8, 32'd6,  32'd2, 0, 0, 0);
        run_op(2, 32'd81,  32'd9, 32'd9,  32'd0, 0, 0, 0);
        run_op(3, 32'd17,  32'd5, 32'd3,  32'd2, 0, 0, 0);
        run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0);
        req_valid = 4'b0000;
        step();

        // Single request from 0 even though the pointer now sits at 1.
        req_valid = 4'b0001;
        run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 1);

        // Backpressure on requester 2 while 0 keeps asking.
        set_op(2, 32'd1000, 32'd33);
        req_valid = 4'b0100;
        #1;
        chk("bp_grant2", 32'(req_ready), 32'b0100);
        req_valid = 4'b0101;
        run_op(2, 32'd1000, 32'd33, 32'd30, 32'd10, 5, 0, 1);
        req_valid = 4'b0000;

        // Stale done in the LAUNCH cycle for requester 1.
        set_op(1, 32'd77, 32'd10);
        req_valid = 4'b0010;
        run_op(1, 32'd77, 32'd10, 32'd7, 32'd7, 0, 1, 1);

        // Zero denominator on requester 3.
        set_op(3, 32'd9, 32'd0);
        req_valid = 4'b1000;
`ifdef DIV_ZERO_FAST_EN
        #1;
        chk("dz_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0000;
        chk("dz_no_start", 32'(div_start), 32'd0);
        chk("dz_valid", 32'(rsp_valid), 32'd1);
        chk("dz_coc", rsp_coc, 32'hFFFF_FFFF);
        chk("dz_res", rsp_res, 32'd9);
        chk("dz_flag", 32'(rsp_dz), 32'd1);
        chk("dz_id", 32'(rsp_id), 32'd3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("dz_done", 32'(rsp_valid), 32'd0);
`else
        run_op(3, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 0, 0, 1);
`endif

        // Reset while requester 2 is in WAIT.
        set_op(2, 32'd50, 32'd5);
        req_valid = 4'b0100;
        #1;
        chk("rw_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        chk("rw_launch", 32'(div_start), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_start", 32'(div_start), 32'd0);
        chk("rw_divnum", div_num, 32'd0);
        chk("rw_divden", div_den, 32'd0);
        chk("rw_id", 32'(rsp_id), 32'd0);
        div_done = 1'b1;
        div_coc  = 32'd10;
        step();
        rst_n = 1'b1;
        step();
        chk("rw_no_rsp1", 32'(rsp_valid), 32'd0);
        step();
        chk("rw_no_rsp2", 32'(rsp_valid), 32'd0);
        div_done = 1'b0;
        div_coc  = 32'd0;
        req_valid = 4'b0110;
        #1;
        chk("rw_rr_reset", 32'(req_ready), 32'b0010);
        req_valid = 4'b0010;
        set_op(1, 32'd21, 32'd4);
        run_op(1, 32'd21, 32'd4, 32'd5, 32'd1, 0, 0, 1);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
